// File: rtl/motor_cmd_sched.sv
// Wheel velocity command sequencer: slew-limited ramp toward the latched PS goal,
// with a command watchdog and an emergency-stop HALT state feeding both motor_ctrl targets.
module motor_cmd_sched #(
    parameter int unsigned CLK_FREQ = 200_000_000,
    parameter int unsigned TICK_HZ  = 1000,
    parameter int unsigned WD_TICKS = 100,
    parameter int unsigned DEF_STEP = 16
) (
    input  logic               clk200M,
    input  logic               rstn,
    input  logic               cmd_valid,
    input  logic signed [31:0] cmd_r,
    input  logic signed [31:0] cmd_l,
    input  logic [15:0]        step,
    input  logic               estop,
    input  logic               clr_fault,
    output logic signed [31:0] r_target_rot_v,
    output logic signed [31:0] l_target_rot_v,
    output logic               tick,
    output logic [1:0]         state,
    output logic               at_target
);

    localparam int unsigned TICK_PERIOD = CLK_FREQ / TICK_HZ;
    localparam int unsigned CNT_W       = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam int unsigned WD_W        = (WD_TICKS > 0) ? $clog2(WD_TICKS + 1) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_PERIOD - 1);
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(WD_TICKS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2,
        ST_HALT = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               tick_q, tick_d;
    logic               at_target_q, at_target_d;
    logic signed [31:0] r_q, r_d, l_q, l_d;
    logic signed [31:0] goal_r_q, goal_r_d, goal_l_q, goal_l_d;
    logic signed [31:0] goal_now_r, goal_now_l;
    logic [15:0]        step_eff;

    // One slew-limited step; the 33-bit difference keeps extreme goals from wrapping.
    function automatic logic signed [31:0] ramp(input logic signed [31:0] cur,
                                                input logic signed [31:0] goal,
                                                input logic [15:0]        stp);
        logic signed [32:0] diff;
        logic [32:0]        mag;
        diff = {goal[31], goal} - {cur[31], cur};
        mag  = diff[32] ? 33'(-diff) : 33'(diff);
        if (mag <= {17'd0, stp}) begin
            return goal;
        end else if (diff[32]) begin
            return cur - $signed({16'd0, stp});
        end else begin
            return cur + $signed({16'd0, stp});
        end
    endfunction

    always_comb begin
        state_d     = state_q;
        wd_d        = wd_q;
        r_d         = r_q;
        l_d         = l_q;
        goal_r_d    = goal_r_q;
        goal_l_d    = goal_l_q;
        step_eff    = (step == 16'd0) ? 16'(DEF_STEP) : step;
        goal_now_r  = (state_q == ST_RUN) ? goal_r_q : 32'sd0;
        goal_now_l  = (state_q == ST_RUN) ? goal_l_q : 32'sd0;
        cnt_d       = (cnt_q == TICK_LAST) ? '0 : cnt_q + 1'b1;
        tick_d      = (cnt_d == TICK_LAST);

        // Ramp uses the goal in force before this cycle's command.
        if (tick_q) begin
            r_d = ramp(r_q, goal_now_r, step_eff);
            l_d = ramp(l_q, goal_now_l, step_eff);
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d  = ST_RUN;
                    goal_r_d = cmd_r;
                    goal_l_d = cmd_l;
                    wd_d     = '0;
                end
            end
            ST_RUN: begin
                if (cmd_valid) begin
                    goal_r_d = cmd_r;
                    goal_l_d = cmd_l;
                    wd_d     = '0;
                end else if (tick_q && (WD_TICKS != 0)) begin
                    wd_d = wd_q + 1'b1;
                    if (wd_d == WD_LAST) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (cmd_valid) begin
                    state_d  = ST_RUN;
                    goal_r_d = cmd_r;
                    goal_l_d = cmd_l;
                    wd_d     = '0;
                end else if (r_q == 32'sd0 && l_q == 32'sd0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (clr_fault) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        if (estop) begin
            state_d  = ST_HALT;
            r_d      = 32'sd0;
            l_d      = 32'sd0;
            goal_r_d = goal_r_q;
            goal_l_d = goal_l_q;
            wd_d     = wd_q;
        end

        at_target_d = (state_d == ST_RUN) ? (r_d == goal_r_d && l_d == goal_l_d)
                                          : (r_d == 32'sd0 && l_d == 32'sd0);
    end

    always_ff @(posedge clk200M) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wd_q        <= '0;
            tick_q      <= 1'b0;
            at_target_q <= 1'b1;
            r_q         <= 32'sd0;
            l_q         <= 32'sd0;
            goal_r_q    <= 32'sd0;
            goal_l_q    <= 32'sd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wd_q        <= wd_d;
            tick_q      <= tick_d;
            at_target_q <= at_target_d;
            r_q         <= r_d;
            l_q         <= l_d;
            goal_r_q    <= goal_r_d;
            goal_l_q    <= goal_l_d;
        end
    end

    assign r_target_rot_v = r_q;
    assign l_target_rot_v = l_q;
    assign tick           = tick_q;
    assign state          = state_q;
    assign at_target      = at_target_q;

endmodule
